// File: rtl/rv32i_run_monitor.sv
// rv32i_run_monitor
//   Watches the fetch-stage PC stream of the RV32I pipeline. It does five things:
//   - counts fetched instructions;
//   - classifies each PC into one of NUM_REGIONS address windows;
//   - records non-sequential PC changes in a first-word-fall-through trace FIFO;
//   - detects a hang (PC stuck) and end-of-program;
//   - runs a fixed pipeline drain before it reports done.
//
// Handshakes:
//   i_pc_valid is a qualifier only; the monitor never back-pressures fetch.
//   The trace FIFO head is offered while o_trace_valid=1 and is popped on a
//   clock edge where o_trace_valid && i_trace_ready.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   i_start             start/restart monitoring (from IDLE, DONE or HANG)
//   i_pc_valid, i_pc    fetched PC qualifier and value
//   i_region_lo/hi      packed inclusive window bounds, entry k at [k*XLEN +: XLEN]
//   o_state             0=IDLE 1=RUN 2=DRAIN 3=DONE 4=HANG (debug/state view)
//   o_inst_count        saturating fetched-PC count since start
//   o_region_idx/hit    window of the last valid PC (lowest matching index)
//   o_done, o_hang      state decodes
//   o_end_reached       DONE was entered because PC reached END_PC
//   o_trace_*           trace FIFO head, level, sticky overflow; i_trace_ready pops
module rv32i_run_monitor #(
   parameter int XLEN         = 32,
   parameter int NUM_REGIONS  = 8,
   parameter int MAX_INST     = 34,
   parameter int DRAIN_CYCLES = 6,
   parameter int STALL_LIMIT  = 10,
   parameter int END_PC       = 304,
   parameter int TRACE_DEPTH  = 8,
   localparam int RW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1,
   localparam int PW = $clog2(TRACE_DEPTH),
   localparam int LW = PW + 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_start,
   input  logic                        i_pc_valid,
   input  logic [XLEN-1:0]             i_pc,
   input  logic [NUM_REGIONS*XLEN-1:0] i_region_lo,
   input  logic [NUM_REGIONS*XLEN-1:0] i_region_hi,
   output logic [2:0]                  o_state,
   output logic [31:0]                 o_inst_count,
   output logic [RW-1:0]               o_region_idx,
   output logic                        o_region_hit,
   output logic                        o_done,
   output logic                        o_hang,
   output logic                        o_end_reached,
   output logic                        o_trace_valid,
   input  logic                        i_trace_ready,
   output logic [XLEN-1:0]             o_trace_from,
   output logic [XLEN-1:0]             o_trace_to,
   output logic [LW-1:0]               o_trace_level,
   output logic                        o_trace_overflow
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_DRAIN = 3'd2,
      ST_DONE  = 3'd3,
      ST_HANG  = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       inst_count_q, inst_count_d;
   logic [31:0]       stall_cnt_q, stall_cnt_d;
   logic [31:0]       drain_cnt_q, drain_cnt_d;
   logic [XLEN-1:0]   prev_pc_q, prev_pc_d;
   logic              have_prev_q, have_prev_d;
   logic              end_reached_q, end_reached_d;
   logic [RW-1:0]     region_idx_q, region_idx_d;
   logic              region_hit_q, region_hit_d;

   logic [2*XLEN-1:0] mem_q [TRACE_DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic              overflow_q, overflow_d;

   logic              match_hit;
   logic [RW-1:0]     match_idx;
   logic              stall_hit;
   logic              jump;
   logic              push;
   logic              pop;
   logic              full;
   logic              push_acc;
   logic              clear_fifo;

   // Next-state and datapath updates.
   always_comb begin
      state_d       = state_q;
      inst_count_d  = inst_count_q;
      stall_cnt_d   = stall_cnt_q;
      drain_cnt_d   = drain_cnt_q;
      prev_pc_d     = prev_pc_q;
      have_prev_d   = have_prev_q;
      end_reached_d = end_reached_q;
      region_idx_d  = region_idx_q;
      region_hit_d  = region_hit_q;
      clear_fifo    = 1'b0;
      push          = 1'b0;
      match_hit     = 1'b0;
      match_idx     = '0;

      // Scan downwards so the lowest matching window wins.
      for (int k = NUM_REGIONS - 1; k >= 0; k--) begin
         if ((i_region_lo[k*XLEN +: XLEN] <= i_pc) && (i_pc <= i_region_hi[k*XLEN +: XLEN])) begin
            match_hit = 1'b1;
            match_idx = RW'(k);
         end
      end
      if (i_pc_valid) begin
         region_hit_d = match_hit;
         region_idx_d = match_idx;
      end

      // PC 0 is treated as "not yet fetching", so holding it never counts as a stall.
      stall_hit = have_prev_q && (i_pc == prev_pc_q) && (prev_pc_q != '0);
      jump      = i_pc_valid && have_prev_q && (i_pc != prev_pc_q + XLEN'(4)) && (i_pc != prev_pc_q);

      case (state_q)
         ST_IDLE, ST_DONE, ST_HANG: begin
            if (i_start) begin
               state_d       = ST_RUN;
               inst_count_d  = '0;
               stall_cnt_d   = '0;
               drain_cnt_d   = '0;
               have_prev_d   = 1'b0;
               end_reached_d = 1'b0;
               clear_fifo    = 1'b1;
            end
         end
         ST_RUN: begin
            if (i_pc_valid) begin
               if (inst_count_q != 32'hFFFF_FFFF) inst_count_d = inst_count_q + 32'd1;
               stall_cnt_d = stall_hit ? stall_cnt_q + 32'd1 : 32'd0;
               prev_pc_d   = i_pc;
               have_prev_d = 1'b1;
               push        = jump;
               // The hang test deliberately uses the count from before this cycle.
               if (stall_cnt_q > 32'(STALL_LIMIT)) begin
                  state_d = ST_HANG;
               end else if (i_pc >= XLEN'(END_PC)) begin
                  state_d       = ST_DONE;
                  end_reached_d = 1'b1;
               end else if (inst_count_d == 32'(MAX_INST)) begin
                  state_d     = ST_DRAIN;
                  drain_cnt_d = '0;
               end
            end
         end
         ST_DRAIN: begin
            if (drain_cnt_q == 32'(DRAIN_CYCLES - 1)) state_d = ST_DONE;
            else drain_cnt_d = drain_cnt_q + 32'd1;
            if (i_pc_valid) begin
               if (inst_count_q != 32'hFFFF_FFFF) inst_count_d = inst_count_q + 32'd1;
               stall_cnt_d = stall_hit ? stall_cnt_q + 32'd1 : 32'd0;
               prev_pc_d   = i_pc;
               have_prev_d = 1'b1;
               push        = jump;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Trace FIFO control. A push into a full FIFO survives only if the head leaves on the same edge.
   always_comb begin
      full       = (level_q == LW'(TRACE_DEPTH));
      pop        = (level_q != '0) && i_trace_ready;
      push_acc   = push && (!full || pop);
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      overflow_d = overflow_q;
      if (clear_fifo) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         level_d    = '0;
         overflow_d = 1'b0;
      end else begin
         if (push_acc) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
         if (push_acc && !pop) level_d = level_q + LW'(1);
         else if (pop && !push_acc) level_d = level_q - LW'(1);
         if (push && full && !pop) overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         inst_count_q  <= '0;
         stall_cnt_q   <= '0;
         drain_cnt_q   <= '0;
         prev_pc_q     <= '0;
         have_prev_q   <= 1'b0;
         end_reached_q <= 1'b0;
         region_idx_q  <= '0;
         region_hit_q  <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         level_q       <= '0;
         overflow_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         inst_count_q  <= inst_count_d;
         stall_cnt_q   <= stall_cnt_d;
         drain_cnt_q   <= drain_cnt_d;
         prev_pc_q     <= prev_pc_d;
         have_prev_q   <= have_prev_d;
         end_reached_q <= end_reached_d;
         region_idx_q  <= region_idx_d;
         region_hit_q  <= region_hit_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         level_q       <= level_d;
         overflow_q    <= overflow_d;
      end
   end

   // Storage needs no reset; level_q qualifies every read.
   always_ff @(posedge clk) begin
      if (rst && push_acc) mem_q[wr_ptr_q] <= {prev_pc_q, i_pc};
   end

   assign o_state          = state_q;
   assign o_inst_count     = inst_count_q;
   assign o_region_idx     = region_idx_q;
   assign o_region_hit     = region_hit_q;
   assign o_done           = (state_q == ST_DONE);
   assign o_hang           = (state_q == ST_HANG);
   assign o_end_reached    = end_reached_q;
   assign o_trace_valid    = (level_q != '0);
   assign o_trace_from     = mem_q[rd_ptr_q][2*XLEN-1:XLEN];
   assign o_trace_to       = mem_q[rd_ptr_q][XLEN-1:0];
   assign o_trace_level    = level_q;
   assign o_trace_overflow = overflow_q;

endmodule

// File: tb/tb_rv32i_run_monitor.sv
// Bench for rv32i_run_monitor: directed PC streams.
// Trace entries are pushed into exp_q before the jump is driven. A negedge
// monitor pops and compares each entry the DUT hands out.
module tb_rv32i_run_monitor;
   localparam int XLEN = 32;
   localparam int NR   = 8;
   localparam int RW   = 3;
   localparam int LW   = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             i_start = 1'b0;
   logic             i_pc_valid = 1'b0;
   logic [XLEN-1:0]  i_pc = '0;
   logic [NR*XLEN-1:0] i_region_lo;
   logic [NR*XLEN-1:0] i_region_hi;
   logic [2:0]       o_state;
   logic [31:0]      o_inst_count;
   logic [RW-1:0]    o_region_idx;
   logic             o_region_hit;
   logic             o_done;
   logic             o_hang;
   logic             o_end_reached;
   logic             o_trace_valid;
   logic             i_trace_ready = 1'b1;
   logic [XLEN-1:0]  o_trace_from;
   logic [XLEN-1:0]  o_trace_to;
   logic [LW-1:0]    o_trace_level;
   logic             o_trace_overflow;

   int pass_cnt = 0;
   int total_cnt = 0;
   logic [63:0] exp_q[$];

   rv32i_run_monitor dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_pc_valid(i_pc_valid), .i_pc(i_pc),
      .i_region_lo(i_region_lo), .i_region_hi(i_region_hi),
      .o_state(o_state), .o_inst_count(o_inst_count), .o_region_idx(o_region_idx),
      .o_region_hit(o_region_hit), .o_done(o_done), .o_hang(o_hang),
      .o_end_reached(o_end_reached), .o_trace_valid(o_trace_valid),
      .i_trace_ready(i_trace_ready), .o_trace_from(o_trace_from), .o_trace_to(o_trace_to),
      .o_trace_level(o_trace_level), .o_trace_overflow(o_trace_overflow)
   );

   // Clock and region windows.
   always #5 clk = ~clk;

   initial begin
      for (int k = 0; k < NR; k++) begin
         i_region_lo[k*XLEN +: XLEN] = 32'hFFFF_FFFF;
         i_region_hi[k*XLEN +: XLEN] = 32'h0;
      end
      i_region_lo[0*XLEN +: XLEN] = 32'd4;   i_region_hi[0*XLEN +: XLEN] = 32'd80;
      i_region_lo[1*XLEN +: XLEN] = 32'd84;  i_region_hi[1*XLEN +: XLEN] = 32'd196;
      i_region_lo[2*XLEN +: XLEN] = 32'd296; i_region_hi[2*XLEN +: XLEN] = 32'd300;
      i_region_lo[3*XLEN +: XLEN] = 32'd284; i_region_hi[3*XLEN +: XLEN] = 32'd296;
   end

   // Scoreboard monitor: the head leaves on the next posedge when valid && ready.
   always @(negedge clk) begin
      if (rst && o_trace_valid && i_trace_ready) begin
         total_cnt++;
         if (exp_q.size() == 0) begin
            $display("FAIL trace_unexpected: got from=%0d to=%0d, expected no entry", o_trace_from, o_trace_to);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            if ({o_trace_from, o_trace_to} == e) pass_cnt++;
            else $display("FAIL trace_entry: got from=%0d to=%0d, expected from=%0d to=%0d",
                          o_trace_from, o_trace_to, e[63:32], e[31:0]);
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic step(input logic v, input logic [31:0] pc);
      i_pc_valid = v;
      i_pc = pc;
      @(posedge clk);
      #1;
   endtask

   task automatic start_run();
      i_start = 1'b1;
      i_pc_valid = 1'b0;
      @(posedge clk);
      #1;
      i_start = 1'b0;
   endtask

   task automatic expect_jump(input logic [31:0] from, input logic [31:0] to);
      exp_q.push_back({from, to});
   endtask

   initial begin
      // Reset
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", o_state, 0);
      check("reset_count", o_inst_count, 0);
      check("reset_level", o_trace_level, 0);
      check("reset_tvalid", o_trace_valid, 0);
      check("reset_ovf", o_trace_overflow, 0);
      check("reset_done_hang", {o_done, o_hang, o_region_hit}, 0);
      rst = 1'b1;

      // Sequential run to MAX_INST, then drain
      start_run();
      check("start_run", o_state, 1);
      for (int i = 0; i < 34; i++) begin
         step(1'b1, 32'(i * 4));
         if (i == 32) check("pre_max_state", o_state, 1);
      end
      check("drain_state", o_state, 2);
      check("drain_count", o_inst_count, 34);
      check("region_132", {o_region_hit, o_region_idx}, {1'b1, 3'd1});
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 32'd0);
         check("drain_hold", o_state, 2);
      end
      step(1'b0, 32'd0);
      check("done_state", o_state, 3);
      check("done_flag", o_done, 1);
      check("done_count", o_inst_count, 34);
      check("done_end", o_end_reached, 0);
      check("done_level", o_trace_level, 0);

      // Jump capture
      start_run();
      check("restart_count", o_inst_count, 0);
      step(1'b1, 32'd196);
      check("region_196", {o_region_hit, o_region_idx}, {1'b1, 3'd1});
      step(1'b1, 32'd200);
      check("no_push_seq", o_trace_level, 0);
      expect_jump(32'd200, 32'd160);
      step(1'b1, 32'd160);
      check("jump_level", o_trace_level, 1);
      check("jump_from", o_trace_from, 200);
      check("jump_to", o_trace_to, 160);
      step(1'b1, 32'd164);
      expect_jump(32'd164, 32'd8);
      step(1'b1, 32'd8);
      step(1'b1, 32'd8);
      step(1'b1, 32'd8);
      check("repeat_no_push", o_trace_level, 0);
      check("count_7", o_inst_count, 7);

      // Hang on a stuck PC
      expect_jump(32'd8, 32'h40);
      for (int j = 1; j <= 13; j++) begin
         step(1'b1, 32'h40);
         if (j == 12) check("pre_hang_state", o_state, 1);
      end
      check("hang_state", o_state, 4);
      check("hang_flag", o_hang, 1);
      check("hang_count", o_inst_count, 20);
      step(1'b1, 32'd100);
      step(1'b1, 32'd200);
      check("hang_frozen", o_inst_count, 20);
      check("hang_no_push", o_trace_level, 0);

      // PC 0 never hangs; END_PC completes
      start_run();
      for (int j = 0; j < 15; j++) step(1'b1, 32'd0);
      check("pc0_no_hang", o_state, 1);
      expect_jump(32'd0, 32'd304);
      step(1'b1, 32'd304);
      check("end_state", o_state, 3);
      check("end_reached", o_end_reached, 1);
      check("end_count", o_inst_count, 16);

      // HANG has priority over END
      start_run();
      check("restart_end_clr", o_end_reached, 0);
      for (int j = 0; j < 12; j++) step(1'b1, 32'h40);
      check("pre_prio_state", o_state, 1);
      expect_jump(32'h40, 32'd304);
      step(1'b1, 32'd304);
      check("prio_hang", o_state, 4);
      check("prio_end_clr", o_end_reached, 0);

      // Overflow with consumer stalled
      start_run();
      i_trace_ready = 1'b0;
      step(1'b1, 32'd100);
      for (int i = 1; i <= 9; i++) begin
         if (i <= 8) expect_jump((i % 2 == 1) ? 32'd100 : 32'd20, (i % 2 == 1) ? 32'd20 : 32'd100);
         step(1'b1, (i % 2 == 1) ? 32'd20 : 32'd100);
      end
      check("ovf_level", o_trace_level, 8);
      check("ovf_flag", o_trace_overflow, 1);
      check("ovf_head", {o_trace_from, o_trace_to}, {32'd100, 32'd20});
      i_trace_ready = 1'b1;
      expect_jump(32'd20, 32'd100);
      step(1'b1, 32'd100);
      check("full_pushpop_level", o_trace_level, 8);
      check("ovf_sticky", o_trace_overflow, 1);
      for (int i = 0; i < 10; i++) step(1'b0, 32'd0);
      check("ovf_drained", o_trace_level, 0);
      check("ovf_sb_empty", exp_q.size(), 0);

      // Region windows
      expect_jump(32'd100, 32'd296);
      step(1'b1, 32'd296);
      check("region_296", {o_region_hit, o_region_idx}, {1'b1, 3'd2});
      expect_jump(32'd296, 32'd82);
      step(1'b1, 32'd82);
      check("region_82", {o_region_hit, o_region_idx}, {1'b0, 3'd0});
      expect_jump(32'd82, 32'd4);
      step(1'b1, 32'd4);
      check("region_4", {o_region_hit, o_region_idx}, {1'b1, 3'd0});
      expect_jump(32'd4, 32'd80);
      step(1'b1, 32'd80);
      check("region_80", {o_region_hit, o_region_idx}, {1'b1, 3'd0});
      step(1'b1, 32'd84);
      check("region_84", {o_region_hit, o_region_idx}, {1'b1, 3'd1});
      expect_jump(32'd84, 32'd300);
      step(1'b1, 32'd300);
      check("region_300", {o_region_hit, o_region_idx}, {1'b1, 3'd2});
      expect_jump(32'd300, 32'd284);
      step(1'b1, 32'd284);
      step(1'b0, 32'd100);
      check("region_hold", {o_region_hit, o_region_idx}, {1'b1, 3'd3});
      check("region_count", o_inst_count, 18);
      start_run();
      check("start_ignored_state", o_state, 1);
      check("start_ignored_count", o_inst_count, 18);
      for (int i = 0; i < 4; i++) step(1'b0, 32'd0);
      check("region_sb_empty", exp_q.size(), 0);

      // Reset mid-run
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_state", o_state, 0);
      check("midrst_count", o_inst_count, 0);
      check("midrst_region", o_region_hit, 0);
      rst = 1'b1;

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/rv32i_run_monitor.md
Name: rv32i_run_monitor

Overview:
- Synthesizable run-control and trace monitor that observes the fetch-stage PC stream of the RV32I pipeline.
- Counts fetched instructions and classifies each PC into one of NUM_REGIONS programmable address windows (program phases).
- Captures every non-sequential PC change into a trace FIFO, detects hangs (PC stuck) and end-of-program.
- Sequences a pipeline drain before reporting done. Replaces bench-only run/stop bookkeeping so it can live in silicon or FPGA debug builds.

Parameters:
- XLEN, 32, PC width.
- NUM_REGIONS, 8, number of PC classification windows (>=1).
- MAX_INST, 34, fetched-instruction count that starts the drain.
- DRAIN_CYCLES, 6, cycles spent in DRAIN before DONE (>=1).
- STALL_LIMIT, 10, repeated-PC count beyond which HANG is declared.
- END_PC, 304, PC at or above which the program is complete.
- TRACE_DEPTH, 8, trace FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- i_start  in  1  start/restart monitoring
- i_pc_valid  in  1  i_pc holds a fetched PC this cycle
- i_pc  in  XLEN  fetch PC
- i_region_lo  in  NUM_REGIONS*XLEN  window lower bounds, inclusive; entry k at bits [k*XLEN +: XLEN]
- i_region_hi  in  NUM_REGIONS*XLEN  window upper bounds, inclusive
- o_state  out  3  0=IDLE 1=RUN 2=DRAIN 3=DONE 4=HANG
- o_inst_count  out  32  fetched PCs counted since start
- o_region_idx  out  max(1,$clog2(NUM_REGIONS))  window of last valid PC
- o_region_hit  out  1  last valid PC matched a window
- o_done  out  1  state==DONE
- o_hang  out  1  state==HANG
- o_end_reached  out  1  DONE entered via END_PC
- o_trace_valid  out  1  FIFO not empty
- i_trace_ready  in  1  consumer pops head when valid&ready
- o_trace_from  out  XLEN  head entry: PC before jump
- o_trace_to  out  XLEN  head entry: PC after jump
- o_trace_level  out  $clog2(TRACE_DEPTH)+1  entries held
- o_trace_overflow  out  1  sticky: a jump was dropped because FIFO full

Behaviour:
- Reset (rst=0 at clk edge): state IDLE; all outputs, counters, prev_pc, have_prev, FIFO pointers and overflow = 0.
- IDLE: i_start -> RUN. Clear inst_count, stall_cnt, drain_cnt, have_prev, FIFO, overflow, end_reached.
- RUN, on each valid cycle, in this order:
  - inst_count+1, saturating at 0xFFFFFFFF.
  - stall_cnt: +1 if have_prev && i_pc==prev_pc && prev_pc!=0, else 0.
  - prev_pc<=i_pc; have_prev<=1.
- RUN transitions, checked on the same valid cycle, priority HANG > END > MAX:
  - stall_cnt (pre-update) > STALL_LIMIT -> HANG.
  - i_pc >= END_PC -> DONE; end_reached=1.
  - new inst_count == MAX_INST -> DRAIN; drain_cnt=0.
- DRAIN: drain_cnt+1 every cycle, valid or not. Counting and tracing continue; stall/END checks disabled. drain_cnt==DRAIN_CYCLES-1 -> DONE next edge.
- DONE/HANG: sticky, counters frozen, no new trace pushes; FIFO still poppable. i_start -> RUN with same clears as IDLE.
- i_start in RUN/DRAIN: ignored.
- Jump detect (RUN or DRAIN): valid && have_prev && i_pc!=prev_pc+4 (mod 2^XLEN) && i_pc!=prev_pc -> push {prev_pc, i_pc}.
- FIFO is first-word-fall-through. Push to full FIFO is dropped and sets overflow, except when a pop occurs the same cycle: then the push is accepted, level unchanged. Push+pop when not full: level unchanged. Pop on empty: no effect.
- Pointers wrap modulo TRACE_DEPTH.
- Region: on each valid cycle, register lowest k with lo[k]<=i_pc<=hi[k] (unsigned). No match -> hit=0, idx=0. One-cycle latency; holds when not valid.
- Reset mid-run aborts immediately to IDLE with all state cleared.

Test Plan:
- Reset, start, PCs 0,4,...,132 one per cycle; MAX_INST=34 -> DRAIN on 34th PC, DONE exactly 6 cycles later; o_inst_count=34, o_end_reached=0, FIFO empty.
- Sequence 196,200,160,164: at PC 160 push {200,160}; o_trace_from=200, o_trace_to=160 next cycle. Sequence 8,8,8: no push.
- PC held at 0x40 for 13 valid cycles -> HANG on 13th cycle (pre-update stall_cnt=11); same PC held at 0 never hangs.
- Jump to 304 while inst_count<MAX_INST -> DONE, o_end_reached=1. Same cycle as stall>limit -> HANG wins.
- TRACE_DEPTH=8, i_trace_ready=0, 9 jumps -> level 8, overflow=1, head is first jump. Full with ready=1 plus jump -> level stays 8, newest entry kept.
- Windows [4,80] and [84,196] plus overlapping [296,300]/[284,296]: PC 296 -> lowest matching idx reported; PC 82 -> hit=0.
